image_ram_arbiter: RTL and testbench
====================================

// Module: image_ram_arbiter
// PURPOSE
//  Shares the single-port 12-bit RGB444 image RAM (15-bit address) between the UART image writer
//  (pixel assembler after 0x5A/width/height header) and the display scan reader. Grants one
//  access per cycle and drives the RAM pins. Returns read data with fixed latency.
//  Uses a priority mode plus an anti-starvation counter so neither side is locked out.
// PARAMETERS
//  DEPTH     19200  valid pixel locations (addresses 0..DEPTH-1); must be <= 32768
//  RD_LAT    1      RAM read latency in cycles, from registered address to i_ram_dout (1..3)
//  MAX_WAIT  4      consecutive denied cycles after which the losing requester is forced to win (1..15)
// PORTS
//  i_clk_sys      in   1   system clock
//  i_rst          in   1   asynchronous reset, active-high
//  i_wr_priority  in   1   1 = image receiving, writes win conflicts; 0 = reads win conflicts
//  i_wr_req       in   1   write request; held with addr/data until o_wr_ack
//  i_wr_addr      in   15  write pixel address
//  i_wr_data      in   12  write pixel {R,G,B} 4 bits each
//  o_wr_ack       out  1   combinational grant; write accepted this cycle
//  i_rd_req       in   1   read request; held with addr until o_rd_ack
//  i_rd_addr      in   15  read pixel address
//  o_rd_ack       out  1   combinational grant; read accepted this cycle
//  o_rd_valid     out  1   one-cycle pulse, o_rd_data valid
//  o_rd_data      out  12  read pixel
//  o_ram_ce       out  1   RAM cycle enable (registered)
//  o_ram_wre      out  1   RAM write enable (registered)
//  o_ram_addr     out  15  RAM address (registered)
//  o_ram_din      out  12  RAM write data (registered)
//  i_ram_dout     in   12  RAM read data
//  o_err_oob      out  1   one-cycle pulse: an acked access had address >= DEPTH
// BEHAVIOUR
//  Reset: every output, the FSM (IDLE), wait counters and the read pipeline are cleared to 0.
//   Asserting i_rst mid-operation drops in-flight reads; no o_rd_valid appears for them after release.
//  Grant (cycle C, combinational): only one request present -> that request is acked.
//   Both present -> the i_wr_priority winner is acked, unless the loser's wait count == MAX_WAIT,
//   in which case the loser is acked. At most one ack per cycle; no ack is given when no request.
//  Wait counters (wr, rd), 4 bits each: +1 per cycle that side requests and is denied;
//   cleared when that side is acked or deasserts request; saturate at MAX_WAIT.
//  Requester advances on the ack edge; it may present the next request in C+1 (back-to-back, 1/cycle).
//  FSM (state = registered RAM cycle type): IDLE / WRITE / READ; next state = type acked in C, else IDLE.
//   WRITE: o_ram_ce=1, o_ram_wre=1, addr/din from the acked write. READ: o_ram_ce=1, o_ram_wre=0.
//   IDLE: o_ram_ce=0, o_ram_wre=0; addr/din hold their last values.
//  Read pipeline: read acked in C -> RAM cycle C+1 -> i_ram_dout sampled at C+1+RD_LAT
//   -> o_rd_valid=1, o_rd_data registered, in C+2+RD_LAT. Total latency RD_LAT+2. Pipelined,
//   one read result per cycle max. o_rd_data holds its value when o_rd_valid=0.
//  Out-of-range (addr >= DEPTH): still acked. Write: o_ram_ce/o_ram_wre stay 0 in C+1.
//   Read: no RAM cycle; o_rd_valid still pulses at C+2+RD_LAT with o_rd_data=12'h000.
//   o_err_oob pulses in C+1 in both cases.
//  Address 32767 with DEPTH=32768 is in range. No wrap-around: addresses are never modified.
// TESTING
//  Writes only, 20 back-to-back (5x4 image, addr 0..19, random data) -> o_wr_ack every cycle;
//   o_ram_wre=1 each following cycle with matching addr/din; no o_err_oob.
//  Both requests held high, i_wr_priority=0, MAX_WAIT=4 -> reads acked 4 cycles; write acked in the
//   5th cycle; reads acked again after it.
//  Same stimulus with i_wr_priority=1 -> writes acked 4 cycles, read forced through in the 5th cycle.
//  RD_LAT=1: read addr 5 acked at cycle 10, i_ram_dout=12'hABC at cycle 12
//   -> o_rd_valid=1, o_rd_data=12'hABC at cycle 13 only.
//  Read addr 19200 (DEPTH=19200) -> acked; o_err_oob at C+1; o_ram_ce=0; o_rd_valid with 12'h000 at C+3.
//  i_rst pulsed one cycle after a read ack -> all outputs 0; no o_rd_valid afterwards; first grant
//   after release is serviced normally.

Source files
------------

// File: rtl/image_ram_arbiter.sv
// Arbiter sharing the single-port RGB444 image RAM between the UART image writer and the
// display scan reader: combinational grant, registered RAM pins, fixed-latency read return.
module image_ram_arbiter #(
    parameter int DEPTH    = 19200,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk_sys,
    input  logic        i_rst,
    input  logic        i_wr_priority,
    input  logic        i_wr_req,
    input  logic [14:0] i_wr_addr,
    input  logic [11:0] i_wr_data,
    output logic        o_wr_ack,
    input  logic        i_rd_req,
    input  logic [14:0] i_rd_addr,
    output logic        o_rd_ack,
    output logic        o_rd_valid,
    output logic [11:0] o_rd_data,
    output logic        o_ram_ce,
    output logic        o_ram_wre,
    output logic [14:0] o_ram_addr,
    output logic [11:0] o_ram_din,
    input  logic [11:0] i_ram_dout,
    output logic        o_err_oob,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [3:0]  MAX_W   = 4'(MAX_WAIT);

    state_t          state;
    logic [3:0]      wr_wait;
    logic [3:0]      rd_wait;
    logic            wr_oob;
    logic            rd_oob;
    logic [RD_LAT:0] pipe_vld;
    logic [RD_LAT:0] pipe_oob;

    assign wr_oob      = {1'b0, i_wr_addr} >= DEPTH_W;
    assign rd_oob      = {1'b0, i_rd_addr} >= DEPTH_W;
    assign o_dbg_state = state;

    // Handshake: a requester raises req with addr/data and holds them until its ack is seen
    // high in a cycle; that cycle is the transfer, and the next request may follow in the
    // very next cycle. At most one of o_wr_ack/o_rd_ack is high, never without a request.
    always_comb begin
        o_wr_ack = 1'b0;
        o_rd_ack = 1'b0;
        if (i_wr_req && i_rd_req) begin
            if (i_wr_priority) begin
                if (rd_wait == MAX_W) o_rd_ack = 1'b1;
                else                  o_wr_ack = 1'b1;
            end else begin
                if (wr_wait == MAX_W) o_wr_ack = 1'b1;
                else                  o_rd_ack = 1'b1;
            end
        end else begin
            o_wr_ack = i_wr_req;
            o_rd_ack = i_rd_req;
        end
    end

    // Starvation counters: count denied cycles of a held request, saturating at MAX_WAIT.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            wr_wait <= 4'd0;
            rd_wait <= 4'd0;
        end else begin
            if (i_wr_req && !o_wr_ack) begin
                if (wr_wait != MAX_W) wr_wait <= wr_wait + 4'd1;
            end else begin
                wr_wait <= 4'd0;
            end
            if (i_rd_req && !o_rd_ack) begin
                if (rd_wait != MAX_W) rd_wait <= rd_wait + 4'd1;
            end else begin
                rd_wait <= 4'd0;
            end
        end
    end

    // RAM cycle FSM: the state is the cycle type being driven on the RAM pins this cycle.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_ram_ce   <= 1'b0;
            o_ram_wre  <= 1'b0;
            o_ram_addr <= 15'd0;
            o_ram_din  <= 12'd0;
            o_err_oob  <= 1'b0;
        end else begin
            state     <= ST_IDLE;
            o_ram_ce  <= 1'b0;
            o_ram_wre <= 1'b0;
            o_err_oob <= 1'b0;
            if (o_wr_ack) begin
                o_err_oob <= wr_oob;
                if (!wr_oob) begin
                    state      <= ST_WRITE;
                    o_ram_ce   <= 1'b1;
                    o_ram_wre  <= 1'b1;
                    o_ram_addr <= i_wr_addr;
                    o_ram_din  <= i_wr_data;
                end
            end else if (o_rd_ack) begin
                o_err_oob <= rd_oob;
                if (!rd_oob) begin
                    state      <= ST_READ;
                    o_ram_ce   <= 1'b1;
                    o_ram_addr <= i_rd_addr;
                end
            end
        end
    end

    // Stage k of the tag pipe is live in cycle C+1+k; stage RD_LAT lines up with i_ram_dout.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            pipe_vld   <= '0;
            pipe_oob   <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= 12'd0;
        end else begin
            pipe_vld   <= {pipe_vld[RD_LAT-1:0], o_rd_ack};
            pipe_oob   <= {pipe_oob[RD_LAT-1:0], o_rd_ack && rd_oob};
            o_rd_valid <= pipe_vld[RD_LAT];
            if (pipe_vld[RD_LAT]) begin
                o_rd_data <= pipe_oob[RD_LAT] ? 12'h000 : i_ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Self-checking bench for image_ram_arbiter: scoreboard queues filled from a grant/memory
// reference model, a RAM model with RD_LAT latency, directed and randomized stimulus.
module tb_image_ram_arbiter;

    localparam int DEPTH    = 19200;
    localparam int RD_LAT   = 1;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_pri = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [14:0] rd_addr = '0;
    logic [11:0] wr_data = '0;
    logic [11:0] ram_dout = '0;
    logic        wr_ack, rd_ack, rd_valid, ram_ce, ram_wre, err_oob;
    logic [11:0] rd_data, ram_din;
    logic [14:0] ram_addr;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic        ce;
        logic        wre;
        logic        oob;
        logic [14:0] addr;
        logic [11:0] din;
    } ram_exp_t;

    logic [11:0] ref_mem [32768];
    logic [11:0] phys_mem[32768];
    logic [11:0] exp_q[$];
    int          due_q[$];
    ram_exp_t    ram_q[$];
    logic [15:0] hist_q[$];
    int          wr_wait = 0;
    int          rd_wait = 0;
    logic [14:0] last_addr = '0;

    image_ram_arbiter #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk_sys    (clk),
        .i_rst        (rst),
        .i_wr_priority(wr_pri),
        .i_wr_req     (wr_req),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_ack     (wr_ack),
        .i_rd_req     (rd_req),
        .i_rd_addr    (rd_addr),
        .o_rd_ack     (rd_ack),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_ram_ce     (ram_ce),
        .o_ram_wre    (ram_wre),
        .o_ram_addr   (ram_addr),
        .o_ram_din    (ram_din),
        .i_ram_dout   (ram_dout),
        .o_err_oob    (err_oob),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor + reference model: checks every cycle, then predicts the next cycle.
    initial begin
        ram_exp_t e;
        logic     ew, er;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_acks", {wr_ack, rd_ack}, 0);
                check("rst_rd", {rd_valid, rd_data}, 0);
                check("rst_ram", {ram_ce, ram_wre, err_oob, ram_addr}, 0);
                check("rst_din", ram_din, 0);
                exp_q.delete();
                due_q.delete();
                ram_q.delete();
                wr_wait   = 0;
                rd_wait   = 0;
                last_addr = '0;
                ram_q.push_back('0);
            end else begin
                if (ram_q.size() != 0) e = ram_q.pop_front();
                else begin
                    e = '0;
                    e.addr = last_addr;
                end
                check("ram_ce", ram_ce, e.ce);
                check("ram_wre", ram_wre, e.wre);
                check("ram_addr", ram_addr, e.addr);
                if (e.wre) check("ram_din", ram_din, e.din);
                check("err_oob", err_oob, e.oob);

                if (due_q.size() != 0 && due_q[0] == cyc) begin
                    check("rd_valid", rd_valid, 1);
                    check("rd_data", rd_data, exp_q[0]);
                    void'(due_q.pop_front());
                    void'(exp_q.pop_front());
                end else begin
                    check("rd_valid_idle", rd_valid, 0);
                end

                // Conflict: priority side wins unless the other side has waited MAX_WAIT.
                ew = wr_req;
                er = rd_req;
                if (wr_req && rd_req) begin
                    ew = wr_pri ? (rd_wait != MAX_WAIT) : (wr_wait == MAX_WAIT);
                    er = !ew;
                end
                check("wr_ack", wr_ack, ew);
                check("rd_ack", rd_ack, er);

                e = '0;
                e.addr = last_addr;
                if (ew) begin
                    if (int'(wr_addr) >= DEPTH) e.oob = 1'b1;
                    else begin
                        e.ce = 1'b1;
                        e.wre = 1'b1;
                        e.addr = wr_addr;
                        e.din = wr_data;
                        last_addr = wr_addr;
                        ref_mem[wr_addr] = wr_data;
                    end
                end else if (er) begin
                    if (int'(rd_addr) >= DEPTH) begin
                        e.oob = 1'b1;
                        exp_q.push_back(12'h000);
                    end else begin
                        e.ce = 1'b1;
                        e.addr = rd_addr;
                        last_addr = rd_addr;
                        exp_q.push_back(ref_mem[rd_addr]);
                    end
                    due_q.push_back(cyc + RD_LAT + 2);
                end
                ram_q.push_back(e);
                wr_wait = (wr_req && !ew) ? ((wr_wait < MAX_WAIT) ? wr_wait + 1 : MAX_WAIT) : 0;
                rd_wait = (rd_req && !er) ? ((rd_wait < MAX_WAIT) ? rd_wait + 1 : MAX_WAIT) : 0;
            end
        end
    end

    // RAM model: data of a read cycle appears RD_LAT cycles later; junk otherwise.
    initial begin
        logic [15:0] h;
        forever begin
            @(negedge clk);
            if (rst) hist_q.delete();
            else begin
                hist_q.push_back({ram_ce && !ram_wre, ram_addr});
                if (hist_q.size() > RD_LAT) begin
                    h = hist_q.pop_front();
                    ram_dout = h[15] ? phys_mem[h[14:0]] : 12'($urandom);
                end
                if (ram_ce && ram_wre) phys_mem[ram_addr] = ram_din;
            end
        end
    end

    task automatic tick(output logic aw, output logic ar);
        @(negedge clk);
        aw = wr_ack;
        ar = rd_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic aw, ar;
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (n) tick(aw, ar);
    endtask

    task automatic do_write(input logic [14:0] a, input logic [11:0] d, output int waited);
        logic aw, ar;
        wr_req = 1'b1; wr_addr = a; wr_data = d; waited = 0;
        forever begin
            tick(aw, ar);
            if (aw || waited > 50) break;
            waited++;
        end
        check("wr_ack_bound", aw, 1);
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [14:0] a, output int waited);
        logic aw, ar;
        rd_req = 1'b1; rd_addr = a; waited = 0;
        forever begin
            tick(aw, ar);
            if (ar || waited > 50) break;
            waited++;
        end
        check("rd_ack_bound", ar, 1);
        rd_req = 1'b0;
    endtask

    function automatic logic [14:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 15'($urandom_range(DEPTH - 1, 32767));
        return 15'($urandom_range(0, 63));
    endfunction

    initial begin
        int   w;
        logic aw, ar;
        for (int i = 0; i < 32768; i++) begin
            ref_mem[i]  = 12'($urandom);
            phys_mem[i] = ref_mem[i];
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // 5x4 image written back to back
        wr_pri = 1'b1;
        for (int a = 0; a < 20; a++) begin
            do_write(15'(a), 12'($urandom), w);
            check("wr_b2b_wait", w, 0);
        end
        idle(3);

        // both held, reads win: write forced through every 5th cycle
        wr_pri = 1'b0; wr_addr = 15'd100; rd_addr = 15'd200;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_data = 12'($urandom);
            tick(aw, ar);
            check("pri0_wr_ack", aw, (k % 5) == 4);
            check("pri0_rd_ack", ar, (k % 5) != 4);
        end
        idle(3);

        // both held, writes win: read forced through every 5th cycle
        wr_pri = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_data = 12'($urandom);
            tick(aw, ar);
            check("pri1_wr_ack", aw, (k % 5) != 4);
            check("pri1_rd_ack", ar, (k % 5) == 4);
        end
        idle(3);

        // read latency: valid exactly RD_LAT+2 cycles after the ack
        do_write(15'd5, 12'hABC, w);
        idle(2);
        do_read(15'd5, w);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat_valid", rd_valid, k == 3);
            if (k == 3) check("lat_data", rd_data, 12'hABC);
        end
        @(posedge clk); #1;
        idle(2);

        // out-of-range read and writes
        do_read(15'(DEPTH), w);
        @(negedge clk);
        check("oob_rd_err", err_oob, 1);
        check("oob_rd_ce", ram_ce, 0);
        @(negedge clk);
        @(negedge clk);
        check("oob_rd_valid", rd_valid, 1);
        check("oob_rd_data", rd_data, 12'h000);
        @(posedge clk); #1;
        do_write(15'(DEPTH), 12'h123, w);
        @(negedge clk);
        check("oob_wr_err", err_oob, 1);
        check("oob_wr_ce", {ram_ce, ram_wre}, 0);
        @(posedge clk); #1;
        do_write(15'd32767, 12'h456, w);
        do_write(15'(DEPTH - 1), 12'h789, w);
        do_read(15'(DEPTH - 1), w);
        idle(5);

        // reset one cycle after a read ack drops the in-flight result
        do_read(15'd7, w);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_no_valid", rd_valid, 0);
        end
        @(posedge clk); #1;
        do_read(15'd5, w);
        check("post_rst_wait", w, 0);
        idle(5);

        // randomized traffic with random priority flips
        for (int k = 0; k < 1500; k++) begin
            if (!wr_req && $urandom_range(0, 2) != 0) begin
                wr_req = 1'b1; wr_addr = rand_addr(); wr_data = 12'($urandom);
            end
            if (!rd_req && $urandom_range(0, 2) != 0) begin
                rd_req = 1'b1; rd_addr = rand_addr();
            end
            if ($urandom_range(0, 63) == 0) wr_pri = ~wr_pri;
            tick(aw, ar);
            if (aw) wr_req = 1'b0;
            if (ar) rd_req = 1'b0;
        end
        idle(10);
        check("drain_empty", due_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
